// File: rtl/appr_err_accum_if.sv
// appr_err_accum_if: valid/ready stream carrying (approximate, exact) product pairs
interface appr_err_accum_if #(parameter int IN_W = 32);
  logic in_valid;
  logic in_ready;
  logic signed [IN_W-1:0] appr_in;
  logic signed [IN_W-1:0] exact_in;
  modport master (output in_valid, appr_in, exact_in, input in_ready);
  modport slave (input in_valid, appr_in, exact_in, output in_ready);
endinterface

// File: rtl/appr_err_accum.sv
// appr_err_accum: two-stage error-statistics accumulator for approximate-multiplier runs
// Optional squared-error sum enabled by defining ERR_SQ_SUM_EN.
module appr_err_accum #(
  parameter int IN_W  = 32,
  parameter int CNT_W = 16,
  parameter int ACC_W = 48
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [CNT_W-1:0]        num_samples,
  appr_err_accum_if.slave         s,
  output logic                    busy,
  output logic                    done,
  output logic signed [ACC_W-1:0] err_sum,
  output logic [ACC_W-1:0]        abs_ref_sum,
  output logic [CNT_W-1:0]        same_cnt,
  output logic [IN_W:0]           max_abs_err,
  output logic [63:0]             err_sq_sum
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state;
  logic [CNT_W-1:0] remaining;
  logic acc, clr, valid_s1, match_s1;
  logic signed [IN_W:0] e, e_s1;
  logic [IN_W:0] abs_e, abse_s1;
  logic [IN_W-1:0] abs_x, absx_s1;
  assign s.in_ready = state == RUN && remaining != '0;
  assign acc = s.in_valid && s.in_ready;
  assign clr = start && (state == IDLE || state == DONE);
  assign busy = state == RUN || state == DRAIN;
  assign done = state == DONE;
  // One extra bit keeps the difference and |-2^(IN_W-1)| exact
  assign e = {s.appr_in[IN_W-1], s.appr_in} - {s.exact_in[IN_W-1], s.exact_in};
  assign abs_e = e[IN_W] ? -e : e;
  assign abs_x = s.exact_in[IN_W-1] ? -s.exact_in : s.exact_in;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      remaining   <= '0;
      valid_s1    <= 1'b0;
      match_s1    <= 1'b0;
      e_s1        <= '0;
      abse_s1     <= '0;
      absx_s1     <= '0;
      err_sum     <= '0;
      abs_ref_sum <= '0;
      same_cnt    <= '0;
      max_abs_err <= '0;
    end else begin
      valid_s1 <= acc;
      if (acc) begin
        e_s1     <= e;
        abse_s1  <= abs_e;
        absx_s1  <= abs_x;
        match_s1 <= s.appr_in == s.exact_in;
      end
      if (valid_s1) begin
        err_sum     <= err_sum + ACC_W'(e_s1);
        abs_ref_sum <= abs_ref_sum + ACC_W'(absx_s1);
        same_cnt    <= same_cnt + CNT_W'(match_s1);
        max_abs_err <= abse_s1 > max_abs_err ? abse_s1 : max_abs_err;
      end
      if (clr) begin
        err_sum     <= '0;
        abs_ref_sum <= '0;
        same_cnt    <= '0;
        max_abs_err <= '0;
        remaining   <= num_samples;
        state       <= num_samples == '0 ? DONE : RUN;
      end else if (state == RUN && acc) begin
        remaining <= remaining - 1'b1;
        state     <= remaining == CNT_W'(1) ? DRAIN : RUN;
      end else if (state == DRAIN) begin
        state <= DONE;
      end
    end
  end
`ifdef ERR_SQ_SUM_EN
  logic [2*IN_W+1:0] sq;
  logic [63:0] sq_s1;
  assign sq = abs_e * abs_e;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sq_s1      <= '0;
      err_sq_sum <= '0;
    end else begin
      if (acc) sq_s1 <= 64'(sq);
      if (clr) err_sq_sum <= '0;
      else if (valid_s1) err_sq_sum <= err_sq_sum + sq_s1;
    end
  end
`else
  assign err_sq_sum = '0;
`endif
endmodule

// File: tb/tb_appr_err_accum.sv
// tb_appr_err_accum: directed self-checking bench for appr_err_accum
module tb_appr_err_accum;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [15:0] num_samples = '0;
  logic busy, done;
  logic signed [47:0] err_sum;
  logic [47:0] abs_ref_sum;
  logic [15:0] same_cnt;
  logic [32:0] max_abs_err;
  logic [63:0] err_sq_sum;
  int checks = 0;
  int failures = 0;
  int acc_n, extra;
  logic signed [31:0] av [4];
  logic signed [31:0] ev [4];
`ifdef ERR_SQ_SUM_EN
  localparam logic [63:0] SQ_BASIC = 64'd125;
  localparam logic [63:0] SQ_EXT   = 64'hFFFF_FFFE_0000_0001;
`else
  localparam logic [63:0] SQ_BASIC = 64'd0;
  localparam logic [63:0] SQ_EXT   = 64'd0;
`endif
  appr_err_accum_if #(.IN_W(32)) ifc ();
  appr_err_accum #(.IN_W(32), .CNT_W(16), .ACC_W(48)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples), .s(ifc),
    .busy(busy), .done(done), .err_sum(err_sum), .abs_ref_sum(abs_ref_sum),
    .same_cnt(same_cnt), .max_abs_err(max_abs_err), .err_sq_sum(err_sq_sum)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_res(input string p, input logic [63:0] s, input logic [63:0] a,
                         input logic [63:0] c, input logic [63:0] m, input logic [63:0] q);
    chk({p, ".err_sum"}, err_sum, s);
    chk({p, ".abs_ref_sum"}, abs_ref_sum, a);
    chk({p, ".same_cnt"}, same_cnt, c);
    chk({p, ".max_abs_err"}, max_abs_err, m);
    chk({p, ".err_sq_sum"}, err_sq_sum, q);
  endtask
  task automatic begin_run(input logic [15:0] n);
    start = 1'b1;
    num_samples = n;
    tick;
    start = 1'b0;
  endtask
  // Drives pairs with valid taken from pat (LSB first, all-ones after 16 cycles);
  // stops right after the n-th accepting edge; optional ignored start pulse at cycle start_at.
  task automatic feed(input logic [15:0] pat, input int n, input int start_at, output int acc_cnt);
    int idx = 0;
    logic a;
    acc_cnt = 0;
    for (int c = 0; c < 40 && idx < n; c++) begin
      ifc.in_valid = c < 16 ? pat[c] : 1'b1;
      ifc.appr_in = av[idx];
      ifc.exact_in = ev[idx];
      start = c == start_at;
      num_samples = c == start_at ? 16'd1 : num_samples;
      a = ifc.in_valid && ifc.in_ready;
      tick;
      start = 1'b0;
      if (a) begin
        idx++;
        acc_cnt++;
      end
    end
    ifc.in_valid = 1'b0;
  endtask
  task automatic load_basic;
    av[0] = 100; ev[0] = 100;
    av[1] = 105; ev[1] = 100;
    av[2] = 90;  ev[2] = 100;
    av[3] = -7;  ev[3] = -7;
  endtask
  initial begin
    ifc.in_valid = 1'b0;
    ifc.appr_in = '0;
    ifc.exact_in = '0;
    tick;
    tick;
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.in_ready", ifc.in_ready, 0);
    chk_res("rst", 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    tick;
    begin_run(16'd0);
    chk("empty.done", done, 1);
    chk("empty.busy", busy, 0);
    chk("empty.in_ready", ifc.in_ready, 0);
    chk_res("empty", 0, 0, 0, 0, 0);
    load_basic;
    begin_run(16'd4);
    chk("basic.busy", busy, 1);
    chk("basic.in_ready", ifc.in_ready, 1);
    chk("basic.start_clr", err_sum, 0);
    feed(16'hFFFF, 4, -1, acc_n);
    chk("basic.accepts", acc_n, 4);
    chk("basic.done_at_last_accept", done, 0);
    chk("basic.busy_drain", busy, 1);
    chk("basic.ready_drain", ifc.in_ready, 0);
    tick;
    chk("basic.done", done, 1);
    chk("basic.busy_done", busy, 0);
    chk_res("basic", 64'hFFFF_FFFF_FFFF_FFFB, 307, 2, 10, SQ_BASIC);
    begin_run(16'd4);
    chk("restart.err_sum_clr", err_sum, 0);
    chk("restart.abs_clr", abs_ref_sum, 0);
    chk("restart.done_low", done, 0);
    feed(16'hFFFF, 4, 2, acc_n);
    tick;
    chk("hazard.done", done, 1);
    chk_res("hazard", 64'hFFFF_FFFF_FFFF_FFFB, 307, 2, 10, SQ_BASIC);
    begin_run(16'd4);
    feed(16'h0069, 4, -1, acc_n);
    chk("bp.accepts", acc_n, 4);
    ifc.in_valid = 1'b1;
    ifc.appr_in = 1000;
    ifc.exact_in = 0;
    #1;
    chk("bp.ready_after_4th", ifc.in_ready, 0);
    extra = 0;
    for (int c = 0; c < 3; c++) begin
      if (ifc.in_valid && ifc.in_ready) extra++;
      tick;
    end
    ifc.in_valid = 1'b0;
    chk("bp.extra_accepts", extra, 0);
    chk("bp.done", done, 1);
    chk_res("bp", 64'hFFFF_FFFF_FFFF_FFFB, 307, 2, 10, SQ_BASIC);
    av[0] = 32'h7FFF_FFFF;
    ev[0] = 32'h8000_0000;
    begin_run(16'd1);
    feed(16'hFFFF, 1, -1, acc_n);
    tick;
    chk("ext.done", done, 1);
    chk_res("ext", 64'd4294967295, 64'd2147483648, 0, 64'h0_FFFF_FFFF, SQ_EXT);
    begin_run(16'd0);
    chk("empty2.done", done, 1);
    chk("empty2.busy", busy, 0);
    chk_res("empty2", 0, 0, 0, 0, 0);
    load_basic;
    begin_run(16'd4);
    feed(16'hFFFF, 2, -1, acc_n);
    tick;
    chk("midrst.partial_abs", abs_ref_sum, 200);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst.busy", busy, 0);
    chk("midrst.done", done, 0);
    chk("midrst.in_ready", ifc.in_ready, 0);
    chk_res("midrst", 0, 0, 0, 0, 0);
    tick;
    rst_n = 1'b1;
    tick;
    begin_run(16'd4);
    feed(16'hFFFF, 4, -1, acc_n);
    tick;
    chk("fresh.done", done, 1);
    chk_res("fresh", 64'hFFFF_FFFF_FFFF_FFFB, 307, 2, 10, SQ_BASIC);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
